// File: rtl/slew_limit_pkg.sv
// Shared definitions for the slew limiter: offset-binary mid-scale, step
// direction type and a parameter sanity check used at elaboration.
package slew_limit_pkg;

    typedef enum logic [1:0] {
        MoveHold = 2'd0,
        MoveUp   = 2'd1,
        MoveDown = 2'd2
    } moveT;

    // Offset-binary zero for an n-bit code.
    function automatic int midScale(input int n);
        return 1 << (n - 1);
    endfunction

    function automatic bit paramsOk(input int n, input int step, input int divide);
        return (n >= 2) && (n <= 30) && (step >= 1) && (step < (1 << n)) && (divide >= 1);
    endfunction

endpackage

// File: rtl/slew_limit_tick_gen.sv
// Update-rate prescaler: counts enabled clocks and pulses Tick on the edge
// that completes each group of Divide enabled clocks.
module tick_gen #(
    parameter int Divide = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Enable,
    output logic Tick
);

    localparam int CW = (Divide > 1) ? $clog2(Divide) : 1;
    localparam logic [CW-1:0] Last = CW'(Divide - 1);

    logic [CW-1:0] count;

    // Tick is combinational so the update lands on the same edge that wraps the count.
    assign Tick = Enable && (count == Last);

    always_ff @(posedge Clk) begin
        if (Reset)
            count <= '0;
        else if (Enable)
            count <= (count == Last) ? '0 : count + CW'(1);
    end

endmodule

// File: rtl/slew_limit.sv
// Rate-of-change limiter: Output moves toward Input by at most Step codes
// per prescaler tick, saturating naturally at 0 and full scale.
module slew_limit
    import slew_limit_pkg::*;
#(
    parameter int N = 8,
    parameter int Step = 1,
    parameter int Divide = 4,
    parameter logic [N-1:0] Initial = N'(midScale(N))
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Enable,
    input  logic [N-1:0] Input,
    output logic [N-1:0] Output,
    output logic         Settled,
    output logic         Rising,
    output logic         Falling
);

    localparam int W = N + 1;

    if (!paramsOk(N, Step, Divide)) begin : gBadParams
        $error("slew_limit: illegal parameters N=%0d Step=%0d Divide=%0d", N, Step, Divide);
    end

    logic         tick;
    logic [W-1:0] up;
    logic [W-1:0] dn;
    logic [W-1:0] inExt;
    logic         dnNeg;
    moveT         move;

    tick_gen #(.Divide(Divide)) uTick (
        .Clk    (Clk),
        .Reset  (Reset),
        .Enable (Enable),
        .Tick   (tick)
    );

    // One extra bit keeps Output+Step from wrapping and flags a negative Output-Step.
    assign inExt = {1'b0, Input};
    assign up    = {1'b0, Output} + W'(Step);
    assign dn    = {1'b0, Output} - W'(Step);
    assign dnNeg = dn[N];

    always_comb begin
        move = MoveHold;
        if (inExt > up)
            move = MoveUp;
        else if (!dnNeg && (inExt < dn))
            move = MoveDown;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Output  <= Initial;
            Settled <= 1'b0;
            Rising  <= 1'b0;
            Falling <= 1'b0;
        end else if (tick) begin
            case (move)
                MoveUp: begin
                    Output  <= up[N-1:0];
                    Settled <= 1'b0;
                    Rising  <= 1'b1;
                    Falling <= 1'b0;
                end
                MoveDown: begin
                    Output  <= dn[N-1:0];
                    Settled <= 1'b0;
                    Rising  <= 1'b0;
                    Falling <= 1'b1;
                end
                default: begin
                    Output  <= Input;
                    Settled <= 1'b1;
                    Rising  <= 1'b0;
                    Falling <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slew_limit.sv
// Bench for slew_limit: two configurations (slow ramp, fast clipping) checked
// every clock against a plain-arithmetic reference model.
module tb_slew_limit;

    localparam int StepA = 1;
    localparam int DivA  = 4;
    localparam int StepB = 16;
    localparam int DivB  = 1;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Enable = 1'b1;
    logic [7:0] inA = 8'h80;
    logic [7:0] inB = 8'h80;
    logic [7:0] outA, outB;
    logic       setA, riseA, fallA, setB, riseB, fallB;

    int tests = 0;
    int failed = 0;

    // Reference state, index 0 = dutA, 1 = dutB.
    int mOut[2];
    int mCnt[2];
    bit mSet[2];
    bit mRise[2];
    bit mFall[2];

    always #5 Clk = ~Clk;

    slew_limit #(.N(8), .Step(StepA), .Divide(DivA), .Initial(8'h80)) dutA (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Input(inA),
        .Output(outA), .Settled(setA), .Rising(riseA), .Falling(fallA)
    );

    slew_limit #(.N(8), .Step(StepB), .Divide(DivB), .Initial(8'h80)) dutB (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Input(inB),
        .Output(outB), .Settled(setB), .Rising(riseB), .Falling(fallB)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move toward the target by at most step codes, once per div enabled clocks.
    task automatic model(input int k, input int step, input int div, input int target);
        if (Reset) begin
            mOut[k] = 128; mCnt[k] = 0;
            mSet[k] = 0; mRise[k] = 0; mFall[k] = 0;
        end else if (Enable) begin
            mCnt[k] = mCnt[k] + 1;
            if (mCnt[k] == div) begin
                mCnt[k] = 0;
                if (target - mOut[k] > step) begin
                    mOut[k] += step; mRise[k] = 1; mFall[k] = 0; mSet[k] = 0;
                end else if (mOut[k] - target > step) begin
                    mOut[k] -= step; mRise[k] = 0; mFall[k] = 1; mSet[k] = 0;
                end else begin
                    mOut[k] = target; mRise[k] = 0; mFall[k] = 0; mSet[k] = 1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        model(0, StepA, DivA, int'(inA));
        model(1, StepB, DivB, int'(inB));
        #1;
        chk("outA",  {1'b0, outA}, 9'(mOut[0]));
        chk("setA",  {8'b0, setA}, {8'b0, mSet[0]});
        chk("riseA", {8'b0, riseA}, {8'b0, mRise[0]});
        chk("fallA", {8'b0, fallA}, {8'b0, mFall[0]});
        chk("outB",  {1'b0, outB}, 9'(mOut[1]));
        chk("setB",  {8'b0, setB}, {8'b0, mSet[1]});
        chk("riseB", {8'b0, riseB}, {8'b0, mRise[1]});
        chk("fallB", {8'b0, fallB}, {8'b0, mFall[1]});
    endtask

    initial begin
        // Reset held two clocks.
        Reset = 1'b1;
        cycle();
        cycle();
        chk("rstOutA", {1'b0, outA}, 9'h080);
        chk("rstFlagsA", {6'b0, setA, riseA, fallA}, 9'h000);
        Reset = 1'b0;

        // Slow ramp 80h -> 84h: one code every 4th clock, then settled.
        inA = 8'h84;
        for (int i = 0; i < 3; i++) cycle();
        chk("preTickA", {1'b0, outA}, 9'h080);
        cycle();
        chk("tick1A", {1'b0, outA}, 9'h081);
        chk("tick1RiseA", {8'b0, riseA}, 9'h001);
        for (int i = 0; i < 12; i++) cycle();
        chk("rampEndA", {1'b0, outA}, 9'h084);
        chk("rampSetA", {8'b0, setA}, 9'h001);

        // Full-scale clip: settle at F8h then ask for FFh.
        inB = 8'hF8;
        for (int i = 0; i < 20 && !(outB == 8'hF8 && setB); i++) cycle();
        chk("reachF8B", {1'b0, outB}, 9'h0F8);
        inB = 8'hFF;
        cycle();
        chk("clipB", {1'b0, outB}, 9'h0FF);
        chk("clipSetB", {8'b0, setB}, 9'h001);

        // Floor: settle at 08h then ask for 00h.
        inB = 8'h08;
        for (int i = 0; i < 30 && !(outB == 8'h08 && setB); i++) cycle();
        chk("reach08B", {1'b0, outB}, 9'h008);
        inB = 8'h00;
        cycle();
        chk("floorB", {1'b0, outB}, 9'h000);
        chk("floorSetB", {8'b0, setB}, 9'h001);

        // Reversal during a freeze: ramp up to 90h, retarget 70h with Enable low.
        inA = 8'hFF;
        for (int i = 0; i < 400 && outA != 8'h90; i++) cycle();
        chk("reach90A", {1'b0, outA}, 9'h090);
        inA = 8'h70;
        Enable = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("freezeA", {1'b0, outA}, 9'h090);
        Enable = 1'b1;
        for (int i = 0; i < DivA; i++) cycle();
        chk("revA", {1'b0, outA}, 9'h08F);
        chk("revFallA", {8'b0, fallA}, 9'h001);

        // Reset mid-ramp at A0h; first tick Divide clocks after release.
        inA = 8'hFF;
        for (int i = 0; i < 400 && outA != 8'hA0; i++) cycle();
        chk("reachA0A", {1'b0, outA}, 9'h0A0);
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        chk("midRstA", {1'b0, outA}, 9'h080);
        for (int i = 0; i < DivA - 1; i++) cycle();
        chk("postRstHoldA", {1'b0, outA}, 9'h080);
        cycle();
        chk("postRstTickA", {1'b0, outA}, 9'h081);

        // Randomized traffic with occasional freezes and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) inA = 8'($urandom);
            if ($urandom_range(0, 3) == 0) inB = 8'($urandom);
            Enable = ($urandom_range(0, 7) != 0);
            Reset  = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
